// File: rtl/sram_pkg.sv
// Shared SRAM definitions for the L2 storage slice: geometry constants,
// word type, and the byte-strobe to bit-mask helper used by the L2 wrapper.
package sram_pkg;

  localparam int SRAM_L2_ADDR_W = 15;
  localparam int SRAM_L2_DATA_W = 64;

  typedef logic [63:0] sram_word_t;

  // Each byte strobe enables all eight bits of its byte lane.
  function automatic logic [63:0] expand_byte_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/sadu_vssd8_ultralow_1p32768x64_core.sv
// Behavioural model of the 32768x64 single-port SRAM macro behind the L2 slice.
// One access per rising clock edge. Reads have 1-cycle latency into a
// registered Q. Writes are bit-masked and never update Q. Reset clears Q
// only, so the contents of ram_core survive a reset (ram_core is left open
// to hierarchical preload).
// Optional: define SRAM_XCHECK_EN to propagate X/Z on control, address and
// mask inputs into Q and the array, and to report them with $error.
module sadu_vssd8_ultralow_1p32768x64_core
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_L2_ADDR_W,
  parameter int DATA_W = SRAM_L2_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ME,
  input  logic              WE,
  input  logic [DATA_W-1:0] WEM,
  input  logic [ADDR_W-1:0] ADR,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] ram_core [0:2**ADDR_W-1];
  logic [DATA_W-1:0] wr_word;

`ifdef SRAM_XCHECK_EN

  // Merge the write data into the old word; unknown mask bits turn that bit X.
  always_comb begin
    wr_word = ram_core[ADR];
    for (int i = 0; i < DATA_W; i++) begin
      if ($isunknown(WEM[i])) wr_word[i] = 1'bx;
      else if (WEM[i])        wr_word[i] = D[i];
    end
  end

  // Access with X-propagation. An unknown ME, or an unknown WE/ADR while
  // enabled, poisons Q. The addressed word is also poisoned when ADR is
  // known, because the cycle may have been a write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if ($isunknown(ME)) begin
      Q <= 'x;
      $error("sram: X/Z on ME");
    end else if (ME) begin
      if ($isunknown(WE) || $isunknown(ADR)) begin
        Q <= 'x;
        $error("sram: X/Z on WE or ADR with ME=1");
        if (!$isunknown(ADR)) ram_core[ADR] <= 'x;
      end else if (WE) begin
        ram_core[ADR] <= wr_word;
      end else begin
        Q <= ram_core[ADR];
      end
    end
  end

`else

  // Merge the write data into the old word under the per-bit mask.
  always_comb begin
    wr_word = (ram_core[ADR] & ~WEM) | (D & WEM);
  end

  // Array write. Reset cancels any access issued in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST && ME && WE) ram_core[ADR] <= wr_word;
  end

  // Registered read data. Q holds on write cycles and on idle cycles.
  always_ff @(posedge CLK) begin
    if (RST)            Q <= '0;
    else if (ME && !WE) Q <= ram_core[ADR];
  end

`endif

endmodule

// File: tb/tb_sadu_vssd8_ultralow_1p32768x64_core.sv
// Directed self-checking bench for the 32768x64 SRAM model.
module tb_sadu_vssd8_ultralow_1p32768x64_core;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        me  = 1'b0;
  logic        we  = 1'b0;
  logic [63:0] wem = '0;
  logic [14:0] adr = '0;
  logic [63:0] d   = '0;
  logic [63:0] q;

  int n_cmp = 0;
  int n_err = 0;

  sadu_vssd8_ultralow_1p32768x64_core dut (
    .CLK(clk), .RST(rst), .ME(me), .WE(we), .WEM(wem), .ADR(adr), .D(d), .Q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [63:0] data, input logic [63:0] m);
    me = 1'b1; we = 1'b1; adr = a; d = data; wem = m;
    cyc();
  endtask

  task automatic rd(input logic [14:0] a);
    me = 1'b1; we = 1'b0; adr = a;
    cyc();
  endtask

  initial begin
    #2;
    // preload word 0, then reset with a concurrent read pending
    wr(15'h0, 64'h1122334455667788, '1);
    rst = 1'b1; rd(15'h0);
    chk("rst_q", q, 64'h0);
    rst = 1'b0; rd(15'h0);
    chk("preload_survives_rst", q, 64'h1122334455667788);

    // full write holds Q, then reads back after 1 cycle
    wr(15'h7FFF, 64'hDEADBEEFCAFEF00D, '1);
    chk("wr_q_hold", q, 64'h1122334455667788);
    rd(15'h7FFF);
    chk("rd_top", q, 64'hDEADBEEFCAFEF00D);

    // masked write
    wr(15'h5, 64'hFFFFFFFFFFFFFFFF, '1);
    wr(15'h5, 64'h0, 64'h00000000FFFF00FF);
    rd(15'h5);
    chk("masked_wr", q, 64'hFFFFFFFF0000FF00);
    // zero mask: a write cycle that changes nothing and holds Q
    wr(15'h5, 64'h0, 64'h0);
    chk("wem0_q_hold", q, 64'hFFFFFFFF0000FF00);
    rd(15'h5);
    chk("wem0_no_change", q, 64'hFFFFFFFF0000FF00);

    // ME=0 hold with write-looking inputs
    wr(15'h8, 64'hAAAAAAAAAAAAAAAA, '1);
    rd(15'h8);
    chk("rd_aaaa", q, 64'hAAAAAAAAAAAAAAAA);
    me = 1'b0; we = 1'b1; d = '0; wem = '1; adr = 15'h8;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("me0_hold_%0d", i), q, 64'hAAAAAAAAAAAAAAAA);
    end
    rd(15'h8);
    chk("me0_array_kept", q, 64'hAAAAAAAAAAAAAAAA);

    // back-to-back write then read of the same word
    wr(15'h3, 64'h0123456789ABCDEF, '1);
    rd(15'h3);
    chk("b2b_rd_after_wr", q, 64'h0123456789ABCDEF);

    // alternate reads every cycle
    for (int i = 0; i < 4; i++) begin
      rd(15'h0);
      chk($sformatf("alt_lo_%0d", i), q, 64'h1122334455667788);
      rd(15'h7FFF);
      chk($sformatf("alt_hi_%0d", i), q, 64'hDEADBEEFCAFEF00D);
    end

    // reset mid-stream cancels a write, next cycle proceeds normally
    rst = 1'b1; wr(15'h3, 64'h0, '1);
    chk("mid_rst_q", q, 64'h0);
    rst = 1'b0; rd(15'h3);
    chk("mid_rst_wr_cancelled", q, 64'h0123456789ABCDEF);

    // byte-strobe helper
    chk("expand_byte_mask", expand_byte_mask(8'b10100101), 64'hFF00FF0000FF00FF);

    me = 1'b0; we = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sadu_vssd8_ultralow_1p32768x64_core.md
# sadu_vssd8_ultralow_1p32768x64_core

Behavioural model of the 32768 × 64 single-port synchronous SRAM macro `saduvssd8ULTRALOW1p32768x64m16b8w1c1p0d0l0rm3sdrw11_core`. It has a per-bit write mask. It is the storage array behind the L2 slice, which holds 256 KB addressed by 64-bit word. The model must be cycle-equivalent to the hard macro. Its array must also be preloadable with `$readmemh` by hierarchical reference.

## Interface
Parameters:
- `ADDR_W`, default 15: word address width. Depth is 2^ADDR_W = 32768.
- `DATA_W`, default 64: word and mask width.

Ports:
- `CLK`, input, 1: single clock. All activity happens on the rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `ME`, input, 1: memory enable. When 0, no access occurs.
- `WE`, input, 1: write enable. 1 = write, 0 = read. Only meaningful when `ME`=1.
- `WEM`, input, DATA_W: per-bit write mask. 1 = the bit is written.
- `ADR`, input, ADDR_W: word address.
- `D`, input, DATA_W: write data.
- `Q`, output, DATA_W: registered read data.

Storage array: an unpacked array named exactly `ram_core`, declared `[DATA_W-1:0] ram_core [0:2**ADDR_W-1]`. It must be reachable as `<inst>.ram_core` for hierarchical `$readmemh`.

## Operation
The table of actions, evaluated at each rising `CLK`, in priority order:
- `RST`=1: `Q` <= 0. `ram_core` is not modified, so preloaded contents survive reset. Any concurrent `ME` access is ignored.
- `ME`=1, `WE`=0 (read): `Q` <= `ram_core[ADR]`.
- `ME`=1, `WE`=1 (write):
  - For each bit i, `ram_core[ADR][i]` <= `WEM[i] ? D[i] : ram_core[ADR][i]`.
  - `Q` holds its previous value; there is no write-through.
  - `WEM` = 0 performs no array change, but still counts as a write cycle, so `Q` holds.
- `ME`=0: no array change, `Q` holds.

Further rules:
- Addressing: `ADR` spans the full depth, so every value is legal and there is no wrap-around. The caller's byte address bits [17:3] map onto `ADR`.
- Back-to-back accesses: every cycle may be an independent access, and there are no stall or busy states. A read in cycle N+1 of the address written in cycle N returns the new data.
- Uninitialised words read as X in simulation. The model does not zero-fill.

## Timing
- Read latency is 1 cycle: `Q` is valid after the rising edge that samples `ME`=1, `WE`=0. `Q` is stable until the next read edge or reset.
- Write completes at the sampling edge.
- No combinational path from any input to `Q`.
- Reset value of `Q` is all zeros. Reset asserted in the middle of a stream cancels that cycle's access, and the next cycle proceeds normally.

## Configuration
- `SRAM_XCHECK_EN` defined: X or Z checking is enabled on every non-reset edge.
  - X/Z on `ME`: sets `Q` to all-X and issues `$error`.
  - X/Z on `WE` or `ADR` when `ME`=1: sets `Q` to all-X and issues `$error`. If it is a write, or `WE` is unknown, the addressed word is set to all-X; if `ADR` is unknown, the array is not modified.
  - X/Z on `WEM` bits during a write: only those bits of the word become X.
- Macro undefined: no checks. Plain two-state-style RTL semantics apply.

## Structure
- Shared package `sram_pkg`:
  - `SRAM_L2_ADDR_W` = 15 and `SRAM_L2_DATA_W` = 64.
  - `sram_word_t` typedef, a `logic [63:0]`.
  - An `expand_byte_mask(logic [7:0]) -> logic [63:0]` function, which the L2 wrapper uses to build `WEM` from byte strobes.
- Single flat module. No sub-module: the array and the output register belong together.

## Test plan
- Reset: drive `RST`=1 with `ME`=1 and `WE`=0 at `ADR`=0 → `Q`=0 after the edge. Preloaded `ram_core[0]`=0x1122334455667788 is read back unchanged once `RST`=0.
- Full write then read: write `ADR`=0x7FFF, `D`=0xDEADBEEFCAFEF00D, `WEM`=all-ones, then read the same address → `Q`=0xDEADBEEFCAFEF00D exactly 1 cycle later. During the write cycle `Q` holds its prior value.
- Masked write:
  - Word `ADR`=5 = 0xFFFFFFFFFFFFFFFF.
  - Write `D`=0, `WEM`=0x00000000FFFF00FF.
  - Read → `Q`=0xFFFFFFFF0000FF00.
- `ME`=0 hold: read 0xAAAA… into `Q`, then drive `ME`=0 with `WE`=1 and `D`=0 for 3 cycles → `Q` and the array are unchanged.
- Back-to-back: write `ADR`=3 in cycle N, read `ADR`=3 in N+1 → new data appears at N+2. Alternate reads of addresses 0 and 0x7FFF every cycle → correct data each cycle.
- With `SRAM_XCHECK_EN`: `ME`=1, `WE`=0, `ADR`=15'bx → `Q` is all-X and `$error` fires. Without the macro no error fires.
